debounce_multi: RTL and testbench

Parametrised multi-channel push-button debouncer for the clock project. It conditions CHANNELS raw board buttons or switches into clean levels, one-cycle press/release pulses and an optional long-press pulse for the time-setting logic. Each channel has an input synchroniser, a tick-timed stability counter and a 4-state FSM. A single prescaler, shared by all channels, generates the sampling tick.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_chan.sv | 110 +++++++++++
 rtl/debounce_multi.sv | 51 +++++
 tb/tb_debounce_multi.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and width helper for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b11,
    ST_WAIT_LOW  = 2'b10
  } state_e;

  // Bits needed to hold values 0..max_value, never less than one.
  function automatic int width_for(input int max_value);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) <= max_value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounced channel: synchroniser, qualify FSM, long-press timer
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 20,
  parameter int LONG_COUNT   = 1000
) (
  input  logic cclk,
  input  logic clr,
  input  logic tick,
  input  logic inp,
  output logic outp,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int CW = width_for(STABLE_COUNT);
  localparam int LW = width_for(LONG_COUNT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_COUNT);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [LW-1:0]          lcnt_q;
  logic                   fired_q;
  logic                   outp_q, rise_q, fall_q, long_q;
  logic [CW-1:0]          wait_base, wait_cnt;
  logic                   qualify;

  always_ff @(posedge cclk) begin
    if (clr) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], inp};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The cycle that first sees a new level already counts its tick, so the
  // stability window starts at detection rather than one cycle later.
  always_comb begin
    wait_base = (state_q == ST_WAIT_HIGH || state_q == ST_WAIT_LOW) ? cnt_q : '0;
    qualify   = tick && (wait_base == CNT_LAST);
    wait_cnt  = wait_base;
    if (tick && (wait_base != CNT_MAX)) wait_cnt = wait_base + CW'(1);
  end

  always_ff @(posedge cclk) begin
    rise_q <= 1'b0;
    fall_q <= 1'b0;
    long_q <= 1'b0;
    if (clr) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      lcnt_q  <= '0;
      fired_q <= 1'b0;
      outp_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOW, ST_WAIT_HIGH: begin
          if (!s) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
          end else if (qualify) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            rise_q  <= 1'b1;
            outp_q  <= 1'b1;
          end else begin
            state_q <= ST_WAIT_HIGH;
            cnt_q   <= wait_cnt;
          end
        end
        ST_HIGH, ST_WAIT_LOW: begin
          if (s) begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            if (state_q == ST_HIGH && tick && LONG_COUNT != 0 && !fired_q) begin
              lcnt_q <= lcnt_q + LW'(1);
              if (lcnt_q + LW'(1) == LCNT_LAST) begin
                long_q  <= 1'b1;
                fired_q <= 1'b1;
              end
            end
          end else if (qualify) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            lcnt_q  <= '0;
            fired_q <= 1'b0;
            fall_q  <= 1'b1;
            outp_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT_LOW;
            cnt_q   <= wait_cnt;
          end
        end
        default: state_q <= ST_LOW;
      endcase
    end
  end

  assign outp       = outp_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign long_press = long_q;

endmodule

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - shared sample-tick prescaler driving CHANNELS debounced inputs
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_COUNT = 20,
  parameter int LONG_COUNT   = 1000
) (
  input  logic                cclk,
  input  logic                clr,
  input  logic [CHANNELS-1:0] inp,
  output logic [CHANNELS-1:0] outp,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int PW = width_for(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge cclk) begin
    if (clr) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_COUNT(STABLE_COUNT),
      .LONG_COUNT  (LONG_COUNT)
    ) u_chan (
      .cclk      (cclk),
      .clr       (clr),
      .tick      (tick),
      .inp       (inp[c]),
      .outp      (outp[c]),
      .rise      (rise[c]),
      .fall      (fall[c]),
      .long_press(long_press[c])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - scoreboard bench for debounce_multi plus a degenerate-parameter instance
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] inp;
  logic [1:0] outp, rise, fall, long_press;

  logic       clr_g;
  logic [0:0] inp_g, outp_g, rise_g, fall_g, long_g;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS(2), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_COUNT(3), .LONG_COUNT(5)
  ) u_dut (
    .cclk(clk), .clr(clr), .inp(inp),
    .outp(outp), .rise(rise), .fall(fall), .long_press(long_press)
  );

  debounce_multi #(
    .CHANNELS(1), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_COUNT(1), .LONG_COUNT(0)
  ) u_deg (
    .cclk(clk), .clr(clr_g), .inp(inp_g),
    .outp(outp_g), .rise(rise_g), .fall(fall_g), .long_press(long_g)
  );

  typedef struct packed {
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lp;
    logic [1:0] outp;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rise0_cyc = 0;
  int  long0_cyc = 0;
  bit  g_long_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic [1:0] f, input logic [1:0] l, input logic [1:0] o);
    ev_t e;
    e.rise = r; e.fall = f; e.lp = l; e.outp = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    ev_t act;
    ev_t expv;
    if (long_g[0]) g_long_seen = 1'b1;
    if ((rise | fall | long_press) != 2'b00) begin
      act = {rise, fall, long_press, outp};
      if (rise[0])       rise0_cyc = cyc;
      if (long_press[0]) long0_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got rise=%b fall=%b long=%b outp=%b, expected no pulse",
                 rise, fall, long_press, outp);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          errors++;
          $display("FAIL scoreboard_event: got rise=%b fall=%b long=%b outp=%b expected rise=%b fall=%b long=%b outp=%b",
                   act.rise, act.fall, act.lp, act.outp, expv.rise, expv.fall, expv.lp, expv.outp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end, expected completion");
    $fatal(1);
  end

  initial begin
    clr   = 1'b1;
    inp   = 2'b11;
    clr_g = 1'b1;
    inp_g = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outp", outp, 2'b00);
      check("reset_pulses", {rise, fall, long_press}, 6'b0);
    end
    clr   = 1'b0;
    clr_g = 1'b0;

    // Held buttons qualify together after reset, then long-press together.
    push(2'b11, 2'b00, 2'b00, 2'b11);
    wait_drain("reset_rise_latency", 14);
    check("reset_outp_after_rise", outp, 2'b11);
    push(2'b00, 2'b00, 2'b11, 2'b11);
    wait_drain("reset_long_press", 20);

    // Clean release / press / release on ch0 while ch1 stays high.
    repeat (4) @(negedge clk);
    inp = 2'b10;
    push(2'b00, 2'b01, 2'b00, 2'b10);
    wait_drain("ch0_first_fall", 14);
    check("ch0_outp_low", outp, 2'b10);
    repeat (4) @(negedge clk);
    inp = 2'b11;
    push(2'b01, 2'b00, 2'b00, 2'b11);
    wait_drain("ch0_clean_rise", 14);
    check("ch0_outp_high", outp, 2'b11);
    inp = 2'b10;
    push(2'b00, 2'b01, 2'b00, 2'b10);
    wait_drain("ch0_clean_fall", 14);
    check("ch0_outp_low_again", outp, 2'b10);

    // Bounce: 3-cycle toggles never qualify; settling produces one rise.
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      inp[0] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_outp_still_low", outp, 2'b10);
    inp[0] = 1'b1;
    push(2'b01, 2'b00, 2'b00, 2'b11);
    wait_drain("bounce_settle_rise", 14);
    push(2'b00, 2'b00, 2'b01, 2'b11);
    wait_drain("ch0_long_press", 20);
    check("long_press_delay", long0_cyc - rise0_cyc, 20);

    // Short low glitch during the hold: no fall, no second long-press.
    repeat (40) @(negedge clk);
    inp[0] = 1'b0;
    repeat (2) @(negedge clk);
    inp[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("outp_after_glitch", outp, 2'b11);

    // clr while pressed drops outp at once without a fall, then re-qualifies.
    clr = 1'b1;
    @(negedge clk);
    #1;
    check("clr_drops_outp", outp, 2'b00);
    check("clr_no_pulses", {rise, fall, long_press}, 6'b0);
    @(negedge clk);
    clr = 1'b0;
    push(2'b11, 2'b00, 2'b00, 2'b11);
    wait_drain("rise_after_clr", 14);
    push(2'b00, 2'b00, 2'b11, 2'b11);
    wait_drain("long_after_clr", 20);

    // Degenerate instance: outp tracks inp after SYNC_STAGES+1 cycles.
    @(negedge clk);
    inp_g = 1'b1;
    @(negedge clk);
    check("deg_rise_1cyc", outp_g, 1'b0);
    @(negedge clk);
    check("deg_rise_2cyc", outp_g, 1'b0);
    @(negedge clk);
    check("deg_rise_3cyc", outp_g, 1'b1);
    inp_g = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("deg_fall_2cyc", outp_g, 1'b1);
    @(negedge clk);
    check("deg_fall_3cyc", outp_g, 1'b0);
    inp_g = 1'b1;
    repeat (20) @(negedge clk);
    check("deg_outp_held", outp_g, 1'b1);
    check("deg_no_long_press", {31'b0, g_long_seen}, 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
